// File: rtl/multicycle_alu_if.sv
// Handshake and operand/result bundle between the pipeline control and the multicycle ALU.
// Master (control/bench): start, alu_op, op_a, op_b.  Slave (ALU): result, carry, zero,
// div_by_zero, busy, done.  No queuing: start only counts while busy is low.
interface multicycle_alu_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             div_by_zero;
    logic             busy;
    logic             done;

    modport master (
        output start, alu_op, op_a, op_b,
        input  result, carry, zero, div_by_zero, busy, done
    );

    modport slave (
        input  start, alu_op, op_a, op_b,
        output result, carry, zero, div_by_zero, busy, done
    );
endinterface

// File: rtl/multicycle_alu.sv
// Execution-stage ALU: single-cycle ADD/SUB/AND/OR/XOR/NOT, iterative shift-add MUL and restoring DIV.
// Latency: 1 cycle for single-cycle ops and DIV-by-zero, WIDTH+1 cycles for MUL/DIV (done pulse).
// Backpressure: busy high while an op is in flight; start outside IDLE is dropped, never queued.
// Ports: clk, rst_n (async active-low), bus (slave modport of multicycle_alu_if).
module multicycle_alu #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_alu_if.slave     bus
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    // acc: MUL partial product / DIV partial remainder
    // a:   MUL shifted multiplicand / DIV dividend shifting out, quotient shifting in
    // b:   MUL multiplier shifting right / DIV divisor
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;

    // Datapath helpers
    logic [WIDTH:0]   sum_w, diff_w;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] step_acc, step_a, step_b;
    logic [WIDTH-1:0] single_res;
    logic             single_carry;

    always_comb begin
        sum_w  = {1'b0, bus.op_a} + {1'b0, bus.op_b};
        diff_w = {1'b0, bus.op_a} - {1'b0, bus.op_b};

        // Restoring step: bring the next dividend bit into the remainder and
        // subtract the divisor only if it fits. The remainder is always below
        // the divisor, so the shifted value fits in WIDTH+1 bits and the
        // subtracted value fits back into WIDTH bits.
        rem_sh = {acc_q, a_q[WIDTH-1]};
        rem_ge = (rem_sh >= {1'b0, b_q});

        if (op_q == OP_MUL) begin
            step_acc = b_q[0] ? (acc_q + a_q) : acc_q;
            step_a   = a_q << 1;
            step_b   = b_q >> 1;
        end else begin
            step_acc = rem_ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
            step_a   = {a_q[WIDTH-2:0], rem_ge};
            step_b   = b_q;
        end

        single_res   = '0;
        single_carry = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                single_res   = sum_w[WIDTH-1:0];
                single_carry = sum_w[WIDTH];
            end
            OP_SUB: begin
                single_res   = diff_w[WIDTH-1:0];
                single_carry = diff_w[WIDTH];   // borrow: a < b unsigned
            end
            OP_AND:  single_res = bus.op_a & bus.op_b;
            OP_OR:   single_res = bus.op_a | bus.op_b;
            OP_XOR:  single_res = bus.op_a ^ bus.op_b;
            default: single_res = ~bus.op_a;  // NOT; MUL/DIV never take this path
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d  = bus.alu_op;
                    dbz_d = 1'b0;
                    if (bus.alu_op == OP_MUL ||
                        (bus.alu_op == OP_DIV && bus.op_b != '0)) begin
                        acc_d   = '0;
                        a_d     = bus.op_a;
                        b_d     = bus.op_b;
                        cnt_d   = CW'(WIDTH);
                        state_d = S_CALC;
                    end else if (bus.alu_op == OP_DIV) begin
                        // Divide by zero skips the iteration entirely
                        result_d = '1;
                        carry_d  = 1'b0;
                        zero_d   = 1'b0;
                        dbz_d    = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        result_d = single_res;
                        carry_d  = single_carry;
                        zero_d   = (single_res == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                a_d   = step_a;
                b_d   = step_b;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Last iteration: commit the step's output straight to the result
                    result_d = (op_q == OP_MUL) ? step_acc : step_a;
                    carry_d  = 1'b0;
                    zero_d   = (((op_q == OP_MUL) ? step_acc : step_a) == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.result      = result_q;
    assign bus.carry       = carry_q;
    assign bus.zero        = zero_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed cases plus random ops against an arithmetic model.
// Each op is issued, its done pulse is awaited under a cycle bound, and latency/result/flags compared.
// Start pulses during CALC and operand changes after acceptance must not disturb the in-flight op.
module tb_multicycle_alu;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [W-1:0] last_res = '0;

    multicycle_alu_if #(.WIDTH(W)) bus ();

    multicycle_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model from the arithmetic definitions, not from the datapath
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output logic dz,
                                  output int lat);
        int ia;
        int ib;
        ia  = int'(a);
        ib  = int'(b);
        r   = '0;
        c   = 1'b0;
        dz  = 1'b0;
        lat = 1;
        case (op)
            3'd0: begin r = W'((ia + ib) % M); c = ((ia + ib) >= M); end
            3'd1: begin r = W'((ia - ib + M) % M); c = (ia < ib); end
            3'd2: begin r = W'((ia * ib) % M); lat = W + 1; end
            3'd3: begin
                if (ib == 0) begin r = W'(M - 1); dz = 1'b1; end
                else begin r = W'(ia / ib); lat = W + 1; end
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = ~a;
        endcase
    endfunction

    // Called at a sample point (posedge+1) while the DUT is IDLE; returns in the following IDLE cycle.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit disturb);
        logic [W-1:0] er;
        logic         ec;
        logic         edz;
        int           lat;
        int           cyc;
        bit           seen;
        model(op, a, b, er, ec, edz, lat);
        bus.start  = 1'b1;
        bus.alu_op = op;
        bus.op_a   = a;
        bus.op_b   = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op_a  = W'($urandom);
        bus.op_b  = W'($urandom);
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= 4 * W) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                chk("busy_calc", bus.busy, 1);
                chk("hold_result", bus.result, last_res);
                chk("dbz_cleared", bus.div_by_zero, 0);
                if (disturb && cyc == 2) begin
                    bus.start  = 1'b1;
                    bus.alu_op = 3'b000;
                end else begin
                    bus.start = 1'b0;
                end
                bus.op_a   = W'($urandom);
                bus.op_b   = W'($urandom);
                @(posedge clk); #1;
                cyc++;
            end
        end
        bus.start = 1'b0;
        chk("done_seen", seen, 1);
        chk("latency", cyc, lat);
        chk("result", bus.result, er);
        chk("carry", bus.carry, ec);
        chk("zero", bus.zero, (er == '0));
        chk("div_by_zero", bus.div_by_zero, edz);
        chk("busy_at_done", bus.busy, 1);
        last_res = er;
        @(posedge clk); #1;
        chk("done_one_pulse", bus.done, 0);
        chk("idle_busy", bus.busy, 0);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.alu_op = 3'b000;
        bus.op_a   = '0;
        bus.op_b   = '0;

        #12;
        chk("rst_result", bus.result, 0);
        chk("rst_carry", bus.carry, 0);
        chk("rst_zero", bus.zero, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'd0, 8'd200, 8'd100, 1'b0);
        chk("plan_add_result", bus.result, 44);
        chk("plan_add_carry", bus.carry, 1);
        run_op(3'd1, 8'd5, 8'd5, 1'b0);
        chk("plan_sub_zero", bus.zero, 1);
        run_op(3'd1, 8'd3, 8'd5, 1'b0);
        chk("plan_sub_result", bus.result, 254);
        run_op(3'd2, 8'd13, 8'd11, 1'b0);
        chk("plan_mul_result", bus.result, 143);
        run_op(3'd2, 8'd255, 8'd2, 1'b0);
        chk("plan_mul_trunc", bus.result, 254);
        run_op(3'd3, 8'd100, 8'd7, 1'b0);
        chk("plan_div_result", bus.result, 14);
        run_op(3'd3, 8'd9, 8'd0, 1'b0);
        chk("plan_div0_result", bus.result, 255);
        chk("plan_div0_flag", bus.div_by_zero, 1);
        run_op(3'd2, 8'd3, 8'd4, 1'b1);
        chk("plan_ignore_result", bus.result, 12);
        // Issued in the IDLE cycle straight after the previous done
        run_op(3'd0, 8'd10, 8'd20, 1'b0);
        chk("plan_b2b_result", bus.result, 30);

        // Reset in the middle of a DIV
        bus.start  = 1'b1;
        bus.alu_op = 3'd3;
        bus.op_a   = 8'd100;
        bus.op_b   = 8'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("abort_result", bus.result, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_carry", bus.carry, 0);
        chk("abort_zero", bus.zero, 0);
        chk("abort_dbz", bus.div_by_zero, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_done", bus.done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", bus.done, 0);
        chk("post_rst_busy", bus.busy, 0);
        last_res = '0;
        run_op(3'd4, 8'hF0, 8'h3C, 1'b0);
        chk("plan_and_result", bus.result, 8'h30);

        // Random ops, with zero divisors forced in now and then
        for (int i = 0; i < 60; i++) begin
            logic [2:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 3'($urandom_range(0, 7));
            a  = W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op(op, a, b, ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
